// File: rtl/make_go_fast_hls_deadlock_report_ctrl.sv
// Deadlock-report sequencer: picks an origin, follows the token round the cycle, clears it, reports once.
// Optional walk timeout is built when MAKE_GO_FAST_DL_TIMEOUT_EN is defined.
module make_go_fast_hls_deadlock_report_ctrl #(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                reset,
    input  logic                clock,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_vec,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                dl_detect_in,
    output logic                report_vld,
    input  logic                report_ready,
    output logic [ID_W-1:0]     report_origin,
    output logic [PROC_NUM-1:0] report_path,
    output logic                report_timeout,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ORIGIN = 3'd1,
        WALK   = 3'd2,
        CLEAR  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t                state_reg;
    logic [ID_W-1:0]       id_reg;
    logic [PROC_NUM-1:0]   path_reg;
    logic [ID_W-1:0]       first_id;
    logic [PROC_NUM-1:0]   id_onehot;
    logic                  token_hit;
    logic                  walk_expired;
    logic                  timeout_bit;

    if (PROC_NUM < 1 || (1 << ID_W) < PROC_NUM || TIMEOUT < 1 || TIMEOUT > 255) begin : g_cfg_err
        $error("make_go_fast_hls_deadlock_report_ctrl: illegal parameter combination");
    end

    // Fixed priority: the lowest flagged process becomes the origin.
    always_comb begin
        first_id = '0;
        for (int p = PROC_NUM - 1; p >= 0; p--) begin
            if (dl_detect_vec[p]) begin
                first_id = ID_W'(p);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PROC_NUM; gi++) begin : g_onehot
            assign id_onehot[gi] = (id_reg == ID_W'(gi));
        end
    endgenerate

    assign token_hit = |(token_vec & id_onehot);

`ifdef MAKE_GO_FAST_DL_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_reg;
    logic       to_reg;

    assign walk_expired = (cnt_reg == CNT_LAST);
    assign timeout_bit  = to_reg;

    // to_reg is rewritten every WALK cycle; the value from the exit cycle is what gets reported.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
            to_reg  <= 1'b0;
        end else begin
            if (state_reg == ORIGIN) begin
                cnt_reg <= '0;
            end else if (state_reg == WALK) begin
                cnt_reg <= cnt_reg + 8'd1;
                to_reg  <= ~token_hit & walk_expired;
            end
        end
    end
`else
    assign walk_expired = 1'b0;
    assign timeout_bit  = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            id_reg    <= '0;
            path_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|dl_detect_vec) begin
                        id_reg    <= first_id;
                        state_reg <= ORIGIN;
                    end
                end
                ORIGIN: begin
                    path_reg  <= id_onehot;
                    state_reg <= WALK;
                end
                WALK: begin
                    path_reg <= path_reg | token_vec;
                    if (token_hit || walk_expired) begin
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    state_reg <= REPORT;
                end
                REPORT: begin
                    if (report_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state, so nothing combinational reaches them from inputs.
    assign origin_vec     = (state_reg == ORIGIN) ? id_onehot : '0;
    assign token_clear    = (state_reg == CLEAR);
    assign dl_detect_in   = (state_reg != IDLE);
    assign busy           = (state_reg != IDLE);
    assign report_vld     = (state_reg == REPORT);
    assign report_origin  = report_vld ? id_reg : '0;
    assign report_path    = report_vld ? path_reg : '0;
    assign report_timeout = report_vld & timeout_bit;

endmodule

// File: tb/tb_make_go_fast_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock-report sequencer: vector table plus hand sequences for timeout,
// backpressure, mid-walk reset and token/timeout collision. Works with or without MAKE_GO_FAST_DL_TIMEOUT_EN.
module tb_make_go_fast_hls_deadlock_report_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] dl_detect_vec;
    logic [3:0] token_vec;
    logic [3:0] origin_vec;
    logic       token_clear;
    logic       dl_detect_in;
    logic       report_vld;
    logic       report_ready;
    logic [1:0] report_origin;
    logic [3:0] report_path;
    logic       report_timeout;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  dl;
        logic [3:0]  tok;
        logic        rdy;
        logic [14:0] exp;
    } vec_t;

    vec_t        tbl [15];
    logic [14:0] zero_e, walk_e, clear_e;
    logic        to_exp;

    make_go_fast_hls_deadlock_report_ctrl #(
        .PROC_NUM(4),
        .ID_W    (2),
        .TIMEOUT (8)
    ) dut (
        .reset         (reset),
        .clock         (clock),
        .dl_detect_vec (dl_detect_vec),
        .token_vec     (token_vec),
        .origin_vec    (origin_vec),
        .token_clear   (token_clear),
        .dl_detect_in  (dl_detect_in),
        .report_vld    (report_vld),
        .report_ready  (report_ready),
        .report_origin (report_origin),
        .report_path   (report_path),
        .report_timeout(report_timeout),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Packing: {origin_vec, token_clear, dl_detect_in, report_vld, report_origin, report_path, report_timeout, busy}
    function automatic logic [14:0] mk(input logic [3:0] org, input logic tc, input logic dli,
                                       input logic vld, input logic [1:0] ro, input logic [3:0] rp,
                                       input logic rto, input logic bsy);
        return {org, tc, dli, vld, ro, rp, rto, bsy};
    endfunction

    function automatic logic [14:0] outs();
        return {origin_vec, token_clear, dl_detect_in, report_vld, report_origin, report_path,
                report_timeout, busy};
    endfunction

    function automatic vec_t mkv(input logic [3:0] dl, input logic [3:0] tok, input logic rdy,
                                 input logic [14:0] exp);
        vec_t v;
        v.dl  = dl;
        v.tok = tok;
        v.rdy = rdy;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [14:0] exp);
        logic [14:0] act;
        act = outs();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end else begin
            $display("ok   %s: outs=%b", nm, act);
        end
    endtask

    // Called at posedge+2: drive, compare at the falling edge, then move to the next cycle.
    task automatic step(input string nm, input logic [3:0] dl, input logic [3:0] tok,
                        input logic rdy, input logic [14:0] exp);
        dl_detect_vec = dl;
        token_vec     = tok;
        report_ready  = rdy;
        #3;
        chk(nm, exp);
        @(posedge clock);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_e  = '0;
        walk_e  = mk(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
        clear_e = mk(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
`ifdef MAKE_GO_FAST_DL_TIMEOUT_EN
        to_exp = 1'b1;
`else
        to_exp = 1'b0;
`endif
        tbl[0]  = mkv(4'b0100, 4'b0000, 1'b1, zero_e);
        tbl[1]  = mkv(4'b0000, 4'b0000, 1'b1, mk(4'b0100, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
        tbl[2]  = mkv(4'b0000, 4'b0000, 1'b1, walk_e);
        tbl[3]  = mkv(4'b0000, 4'b0010, 1'b1, walk_e);
        tbl[4]  = mkv(4'b0000, 4'b1000, 1'b1, walk_e);
        tbl[5]  = mkv(4'b0000, 4'b0100, 1'b1, walk_e);
        tbl[6]  = mkv(4'b0000, 4'b0000, 1'b1, clear_e);
        tbl[7]  = mkv(4'b0000, 4'b0000, 1'b1, mk(4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b1110, 1'b0, 1'b1));
        tbl[8]  = mkv(4'b0000, 4'b0000, 1'b1, zero_e);
        tbl[9]  = mkv(4'b1010, 4'b0000, 1'b1, zero_e);
        tbl[10] = mkv(4'b0000, 4'b0000, 1'b1, mk(4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
        tbl[11] = mkv(4'b0001, 4'b0010, 1'b1, walk_e);
        tbl[12] = mkv(4'b0001, 4'b0000, 1'b1, clear_e);
        tbl[13] = mkv(4'b0000, 4'b0000, 1'b1, mk(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1));
        tbl[14] = mkv(4'b0000, 4'b0000, 1'b1, zero_e);

        reset         = 1'b0;
        dl_detect_vec = 4'b1111;
        token_vec     = 4'b1111;
        report_ready  = 1'b1;
        #12;
        chk("reset_state", zero_e);
        @(posedge clock);
        #2;
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step($sformatf("tbl[%0d]", i), tbl[i].dl, tbl[i].tok, tbl[i].rdy, tbl[i].exp);
        end

        // Token never returns: timeout exit after 8 WALK cycles, or an endless walk without the counter.
        step("to_idle", 4'b0001, 4'b0000, 1'b1, zero_e);
        step("to_origin", 4'b0000, 4'b0000, 1'b1, mk(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
        for (int i = 0; i < 8; i++) begin
            step($sformatf("to_walk%0d", i), 4'b0000, 4'b0000, 1'b1, walk_e);
        end
`ifndef MAKE_GO_FAST_DL_TIMEOUT_EN
        for (int i = 8; i < 20; i++) begin
            step($sformatf("to_walk%0d", i), 4'b0000, 4'b0000, 1'b1, walk_e);
        end
        step("to_return", 4'b0000, 4'b0001, 1'b1, walk_e);
`endif
        step("to_clear", 4'b0000, 4'b0000, 1'b1, clear_e);

        // Backpressure: report held for 10 cycles, released on the 11th.
        for (int i = 0; i < 10; i++) begin
            step($sformatf("hold%0d", i), 4'b0000, 4'b0000, 1'b0,
                 mk(4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, to_exp, 1'b1));
        end
        step("hold_release", 4'b0000, 4'b0000, 1'b1,
             mk(4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, to_exp, 1'b1));
        step("after_release", 4'b0000, 4'b0000, 1'b1, zero_e);

        // Asynchronous reset in the middle of a walk.
        step("rs_idle", 4'b0100, 4'b0000, 1'b1, zero_e);
        step("rs_origin", 4'b0000, 4'b0000, 1'b1, mk(4'b0100, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
        step("rs_walk", 4'b0000, 4'b0000, 1'b1, walk_e);
        reset = 1'b0;
        #1;
        chk("rs_async", zero_e);
        @(posedge clock);
        #2;
        reset = 1'b1;
        step("rs_after", 4'b0000, 4'b0000, 1'b1, zero_e);
        step("rs_new", 4'b1000, 4'b0000, 1'b1, zero_e);
        step("rs_origin2", 4'b0000, 4'b0000, 1'b1, mk(4'b1000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
        step("rs_walk2", 4'b0000, 4'b1000, 1'b1, walk_e);
        step("rs_clear2", 4'b0000, 4'b0000, 1'b1, clear_e);
        step("rs_report2", 4'b0000, 4'b0000, 1'b1, mk(4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1));
        step("rs_idle2", 4'b0000, 4'b0000, 1'b1, zero_e);

        // Token returns on the very cycle the counter would expire: return wins.
        step("tie_idle", 4'b0010, 4'b0000, 1'b1, zero_e);
        step("tie_origin", 4'b0000, 4'b0000, 1'b1, mk(4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
        for (int i = 0; i < 7; i++) begin
            step($sformatf("tie_walk%0d", i), 4'b0000, 4'b0000, 1'b1, walk_e);
        end
        step("tie_walk7", 4'b0000, 4'b0011, 1'b1, walk_e);
        step("tie_clear", 4'b0000, 4'b0000, 1'b1, clear_e);
        step("tie_report", 4'b0000, 4'b0000, 1'b1, mk(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0011, 1'b0, 1'b1));
        step("tie_idle2", 4'b0000, 4'b0000, 1'b1, zero_e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
